// File: rtl/uart_pkg.sv
// Shared UART subsystem constants: scheduler FSM encoding, system clock and
// baud divisors for the 12 MHz clock domain.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  localparam int UART_CLK_HZ = 12_000_000;

  // Clock cycles per bit at the supported baud rates.
  localparam int BAUD_DIV_9600 = 1250;
  localparam int BAUD_DIV_2400 = 5000;
  localparam int BAUD_DIV_600  = 20000;
  localparam int BAUD_DIV_110  = 109091;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. Returns the first
// asserted request searching upward from last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] pick,
  output logic [IDXW-1:0] sel
);

  always_comb begin : search
    logic [IDXW-1:0] cand;
    logic            found;
    pick  = '0;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        sel        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters,
// with bounded bursts and a post-frame idle gap. Optional watchdog: UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter int          MAX_BURST   = 7,
  parameter int          GAP_CYC     = 1250,
  parameter logic [19:0] TIMEOUT_CYC = 20'd150000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              sched_busy,
  output logic              err
);

  localparam int IDXW = $clog2(NREQ);
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int GW   = $clog2(GAP_CYC + 1);

  sched_state_e    state_q, state_d;
  logic [IDXW-1:0] sel_q, sel_d, last_q, last_d, pick_sel;
  logic [NREQ-1:0] pick_oh, sel_oh;
  logic [BW-1:0]   burst_q, burst_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [19:0]     wd_q, wd_d;
  logic            err_q, err_d;
`endif

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_oh),
    .sel  (pick_sel)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= IDXW'(NREQ - 1);
      burst_q   <= '0;
      gap_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    burst_d   = burst_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    wd_d      = '0;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          sel_d     = pick_sel;
          tx_data_d = req_data[{pick_sel, 3'b000} +: 8];
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_done) begin
          gap_d   = GW'(GAP_CYC - 1);
          state_d = ST_GAP;
        end else if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          gap_d   = GW'(GAP_CYC - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (req[sel_q] && burst_q < BW'(MAX_BURST)) begin
          tx_data_d = req_data[{sel_q, 3'b000} +: 8];
          state_d   = ST_START;
        end else begin
          last_d  = sel_q;
          burst_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_TX_SCHED_TIMEOUT_EN
    // A frame completing in the same cycle as the timeout still counts as done.
    if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && !tx_done) begin
      if (wd_q == TIMEOUT_CYC - 20'd1) begin
        err_d   = 1'b1;
        last_d  = sel_q;
        burst_d = '0;
        state_d = ST_IDLE;
      end else begin
        wd_d = wd_q + 20'd1;
      end
    end
`endif
  end

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
    tx_start      = (state_q == ST_START);
    ack           = (state_q == ST_START) ? sel_oh : '0;
    gnt           = (state_q != ST_IDLE) ? sel_oh : '0;
    sched_busy    = (state_q != ST_IDLE);
  end

  assign tx_data = tx_data_q;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester and transmitter-core models
// drive the DUT; a monitor checks every tx_start against queued expectations.
module tb_uart_tx_sched;

  localparam int          NREQ = 4;
  localparam int          GAP  = 1250;
  localparam logic [19:0] TO   = 20'd1000;

  logic              clk, nrst;
  logic [NREQ-1:0]   req, ack, gnt;
  logic [8*NREQ-1:0] req_data;
  logic              tx_start, tx_busy, tx_done, sched_busy, err;
  logic [7:0]        tx_data;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  uart_tx_sched #(.NREQ(NREQ), .MAX_BURST(7), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .gnt        (gnt),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .sched_busy (sched_busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester model: per-index byte FIFO; hold=1 keeps req high across grants,
  // hold=0 drops req while granted so each grant carries one byte.
  logic [7:0] rmem [NREQ][16];
  int         rhead [NREQ];
  int         rtail [NREQ];
  bit         rhold [NREQ];

  task automatic load(int i, logic [7:0] b);
    rmem[i][rtail[i]] = b;
    rtail[i]++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (rhead[i] != rtail[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
      rhold[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && rhead[i] != rtail[i]) rhead[i]++;
        req[i] = (rhead[i] != rtail[i]) && (rhold[i] || !gnt[i]);
        req_data[8*i +: 8] = (rhead[i] != rtail[i]) ? rmem[i][rhead[i]] : 8'h00;
      end
    end
  end

  // Transmitter core model: 0 = normal (busy then done), 1 = fast (done without busy),
  // 2 = dead (busy forever).
  int core_mode = 0;
  int core_cnt  = 0;
  int done_cyc  = 0;
  bit have_done = 1'b0;

  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (!nrst) begin
        core_cnt  = 0;
        tx_busy   = 1'b0;
        have_done = 1'b0;
      end else if (tx_start) begin
        core_cnt = (core_mode == 1) ? 3 : 10;
        tx_busy  = (core_mode != 1);
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0 && core_mode != 2) begin
          tx_busy   = 1'b0;
          tx_done   = 1'b1;
          done_cyc  = cyc;
          have_done = 1'b1;
        end
      end
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];
  bit   exact_gap = 1'b0;

  task automatic push(int idx, logic [7:0] d, int due);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_start: tx_data=%0h ack=%0b required=no start (cycle %0d)",
                   tx_data, ack, cyc);
        end else begin
          e = sb.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.data));
          chk("ack", 32'(ack), 32'(1 << e.idx));
          chk("gnt", 32'(gnt), 32'(1 << e.idx));
          if (e.due > 0) chk("start_cycle", cyc, e.due);
        end
        if (have_done) begin
          if (exact_gap) chk("gap_exact", cyc, done_cyc + 1 + GAP);
          else chk("gap_min", 32'(cyc >= done_cyc + 1 + GAP), 32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_idle(string name, int max);
    int n = 0;
    while ((sched_busy || sb.size() != 0 || pending()) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  task automatic wait_start(string name);
    int n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 50), 32'd1);
  endtask

  initial begin : stim
    int n, s;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    nrst = 1'b1;

    // Single request: start two cycles after the load (req rises next cycle).
    load(0, 8'hA5);
    push(0, 8'hA5, cyc + 2);
    wait_idle("single_done", 3000);

    // Fast core: burst of two, second start exactly GAP+1 after tx_done.
    do_reset();
    core_mode = 1;
    exact_gap = 1'b1;
    rhold[0]  = 1'b1;
    load(0, 8'h5A);
    load(0, 8'h3C);
    push(0, 8'h5A, cyc + 2);
    push(0, 8'h3C, 0);
    wait_idle("fast_done", 4000);
    exact_gap = 1'b0;
    rhold[0]  = 1'b0;
    core_mode = 0;

    // Round robin, one byte per grant: order 0,1,2,3,0.
    do_reset();
    load(0, 8'h10);
    load(0, 8'h14);
    load(1, 8'h11);
    load(2, 8'h12);
    load(3, 8'h13);
    push(0, 8'h10, cyc + 2);
    push(1, 8'h11, 0);
    push(2, 8'h12, 0);
    push(3, 8'h13, 0);
    push(0, 8'h14, 0);
    wait_idle("rr_done", 8000);

    // Burst cap: 7 from requester 2, then requester 1, then 2 resumes for 3.
    do_reset();
    rhold[2] = 1'b1;
    for (int b = 0; b < 10; b++) load(2, 8'(8'h20 + b));
    push(2, 8'h20, cyc + 2);
    for (int b = 1; b < 7; b++) push(2, 8'(8'h20 + b), 0);
    push(1, 8'h31, 0);
    for (int b = 7; b < 10; b++) push(2, 8'(8'h20 + b), 0);
    n = 0;
    while (ack[2] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("burst_first_ack", 32'(n < 100), 32'd1);
    rhold[1] = 1'b1;
    load(1, 8'h31);
    wait_idle("burst_done", 16000);
    rhold[1] = 1'b0;
    rhold[2] = 1'b0;

    // Reset during WAIT_DONE, then req=1001 grants index 0 first.
    do_reset();
    load(0, 8'h77);
    push(0, 8'h77, cyc + 2);
    wait_start("mid_start_seen");
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", 32'(sched_busy), 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_sched_busy", 32'(sched_busy), 32'd0);
    nrst = 1'b1;
    load(0, 8'h80);
    load(3, 8'h83);
    push(0, 8'h80, cyc + 2);
    push(3, 8'h83, 0);
    wait_idle("after_rst_done", 4000);

    // Dead core: watchdog (if built in) or indefinite wait.
    do_reset();
    core_mode = 2;
    load(1, 8'h99);
    push(1, 8'h99, cyc + 2);
    wait_start("wd_start_seen");
    s = cyc;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    n = 0;
    while (err !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    // Wait cycles are s+1..s+1000; err is registered at the end of the 1000th.
    chk("wd_err_cycle", cyc, s + 1001);
    chk("wd_idle", 32'(sched_busy), 32'd0);
    chk("wd_gnt_released", 32'(gnt), 32'd0);
    repeat (5) @(negedge clk);
    chk("wd_err_sticky", 32'(err), 32'd1);
`else
    repeat (1500) @(negedge clk);
    chk("nowd_err", 32'(err), 32'd0);
    chk("nowd_still_busy", 32'(sched_busy), 32'd1);
    chk("nowd_gnt_held", 32'(gnt), 32'b0010);
`endif
    do_reset();
    chk("err_after_reset", 32'(err), 32'd0);
    core_mode = 0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: cycle=%0d required=finish before 90000", cyc);
    $fatal(1, "global timeout");
  end

endmodule
